irrigation_sequencer: RTL and testbench

Sequences one irrigation run from request to completion. It latches the sprinkler or dripper mode and drives the matching actuator. It counts the run time down as a BCD MM:S0 value for the 7-segment path, and enforces a post-run lockout. It sits between the irrigation prerequisite/selector logic and the actuator and display outputs, replacing the ad-hoc timer reset and initialisation glue.

---
 rtl/irrigation_pkg.sv | 25 ++
 rtl/irrigation_sequencer_bcd_countdown.sv | 68 ++++++
 rtl/irrigation_sequencer.sv | 142 ++++++++++++++
 tb/tb_irrigation_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared types, digit limits and preset conversion for the irrigation sequencer.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        LOCKOUT = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SECONDS_D_MAX = 4'd5;
    localparam bcd_t MINUTES_U_MAX = 4'd9;
    localparam bcd_t MINUTES_D_MAX = 4'd3;

    // Minutes (0..39) to packed BCD {tens, units}; used on parameters only.
    function automatic logic [7:0] minutes_to_bcd(input int unsigned m);
        logic [7:0] r;
        r[7:4] = 4'(m / 10);
        r[3:0] = 4'(m % 10);
        return r;
    endfunction

endpackage

// File: rtl/irrigation_sequencer_bcd_countdown.sv
// MM:S0 BCD down-counter: clear beats load beats decrement; saturates at 00:0.
module bcd_countdown
    import irrigation_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  logic dec,
    input  bcd_t load_md,
    input  bcd_t load_mu,
    output bcd_t minutes_d,
    output bcd_t minutes_u,
    output bcd_t seconds_d,
    output logic at_one
);

    bcd_t md_q, md_d, mu_q, mu_d, sd_q, sd_d;
    logic at_zero;

    assign at_zero   = (md_q == 4'd0) && (mu_q == 4'd0) && (sd_q == 4'd0);
    assign at_one    = (md_q == 4'd0) && (mu_q == 4'd0) && (sd_q == 4'd1);
    assign minutes_d = md_q;
    assign minutes_u = mu_q;
    assign seconds_d = sd_q;

    // Next count: clear, load preset, or one 10 s step down with borrow.
    always_comb begin
        md_d = md_q;
        mu_d = mu_q;
        sd_d = sd_q;
        if (clear) begin
            md_d = 4'd0;
            mu_d = 4'd0;
            sd_d = 4'd0;
        end else if (load) begin
            md_d = (load_md > MINUTES_D_MAX) ? MINUTES_D_MAX : load_md;
            mu_d = load_mu;
            sd_d = 4'd0;
        end else if (dec && !at_zero) begin
            if (sd_q != 4'd0) begin
                sd_d = sd_q - 4'd1;
            end else begin
                sd_d = SECONDS_D_MAX;
                if (mu_q != 4'd0) begin
                    mu_d = mu_q - 4'd1;
                end else begin
                    mu_d = MINUTES_U_MAX;
                    md_d = md_q - 4'd1;
                end
            end
        end
    end

    // Count registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            md_q <= 4'd0;
            mu_q <= 4'd0;
            sd_q <= 4'd0;
        end else begin
            md_q <= md_d;
            mu_q <= mu_d;
            sd_q <= sd_d;
        end
    end

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation run sequencer: mode latch, actuator drive, BCD countdown, lockout.
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int unsigned SPRINKLER_MINUTES = 15,
    parameter int unsigned DRIPPER_MINUTES   = 30,
    parameter int unsigned LOCKOUT_TICKS     = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       irrigation_on,
    input  logic       splinker_mode_on,
    input  logic       conflicting_values,
    input  logic       abort,
    output logic       splinker_bomb,
    output logic       dripper_valvule,
    output logic [3:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [3:0] seconds_d,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] SPR_BCD  = minutes_to_bcd(SPRINKLER_MINUTES);
    localparam logic [7:0] DRP_BCD  = minutes_to_bcd(DRIPPER_MINUTES);
    localparam logic [7:0] LOCK_END = 8'(LOCKOUT_TICKS - 1);

    state_e     state_q, state_d;
    logic       mode_q, mode_d;
    logic [7:0] lock_q, lock_d;
    logic       spr_q, spr_d, drp_q, drp_d, busy_q, busy_d, done_q, done_d;
    logic       cnt_clear, cnt_load, cnt_dec, at_one;

    bcd_countdown u_cnt (
        .clock     (clock),
        .reset     (reset),
        .clear     (cnt_clear),
        .load      (cnt_load),
        .dec       (cnt_dec),
        .load_md   (splinker_mode_on ? SPR_BCD[7:4] : DRP_BCD[7:4]),
        .load_mu   (splinker_mode_on ? SPR_BCD[3:0] : DRP_BCD[3:0]),
        .minutes_d (minutes_d),
        .minutes_u (minutes_u),
        .seconds_d (seconds_d),
        .at_one    (at_one)
    );

    // Next state, counter controls and registered outputs; abort > fault > request drop > tick.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        lock_d    = lock_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!abort && irrigation_on && !conflicting_values) begin
                    mode_d   = splinker_mode_on;
                    cnt_load = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end else if (conflicting_values) begin
                    state_d = HOLD;
                end else if (!irrigation_on) begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end else if (tick) begin
                    cnt_dec = 1'b1;
                    if (at_one) begin
                        done_d  = 1'b1;
                        lock_d  = 8'd0;
                        state_d = LOCKOUT;
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end else if (!conflicting_values) begin
                    if (irrigation_on) begin
                        state_d = RUN;
                    end else begin
                        cnt_clear = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            LOCKOUT: begin
                if (abort) begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end else if (tick) begin
                    if (lock_q == LOCK_END) begin
                        state_d = IDLE;
                    end else begin
                        lock_d = lock_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        spr_d  = (state_d == RUN) && mode_d;
        drp_d  = (state_d == RUN) && !mode_d;
        busy_d = (state_d != IDLE);
    end

    // State, mode latch, lockout counter and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            lock_q  <= 8'd0;
            spr_q   <= 1'b0;
            drp_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lock_q  <= lock_d;
            spr_q   <= spr_d;
            drp_q   <= drp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign splinker_bomb   = spr_q;
    assign dripper_valvule = drp_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Scoreboard bench: an integer-count reference model pushes expected outputs per cycle.
module tb_irrigation_sequencer;

    localparam int SPR = 15;
    localparam int DRP = 30;
    localparam int LT  = 6;

    logic clock = 1'b0;
    logic reset, tick, irrigation_on, splinker_mode_on, conflicting_values, abort;
    logic splinker_bomb, dripper_valvule, busy, done;
    logic [3:0] minutes_d, minutes_u, seconds_d;

    int checks = 0;
    int failures = 0;

    // model state: 0 idle, 1 run, 2 hold, 3 lockout; rem in 10 s units
    int m_st = 0, m_rem = 0, m_lock = 0;
    bit m_mode = 0, m_done = 0;
    logic [15:0] sb_q[$];

    always #5 clock = ~clock;

    irrigation_sequencer #(
        .SPRINKLER_MINUTES (SPR),
        .DRIPPER_MINUTES   (DRP),
        .LOCKOUT_TICKS     (LT)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .tick               (tick),
        .irrigation_on      (irrigation_on),
        .splinker_mode_on   (splinker_mode_on),
        .conflicting_values (conflicting_values),
        .abort              (abort),
        .splinker_bomb      (splinker_bomb),
        .dripper_valvule    (dripper_valvule),
        .minutes_d          (minutes_d),
        .minutes_u          (minutes_u),
        .seconds_d          (seconds_d),
        .busy               (busy),
        .done               (done)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_outs();
        return {splinker_bomb, dripper_valvule, minutes_d, minutes_u, seconds_d, busy, done};
    endfunction

    function automatic logic [11:0] disp();
        return {minutes_d, minutes_u, seconds_d};
    endfunction

    task automatic model(input bit r, t, irr, md, cf, ab);
        int m;
        logic [15:0] e;
        m_done = 0;
        if (r) begin
            m_st = 0; m_rem = 0; m_mode = 0; m_lock = 0;
        end else begin
            case (m_st)
                0: if (!ab && irr && !cf) begin
                       m_mode = md; m_rem = (md ? SPR : DRP) * 6; m_st = 1;
                   end
                1: if (ab) begin m_st = 0; m_rem = 0; end
                   else if (cf) m_st = 2;
                   else if (!irr) begin m_st = 0; m_rem = 0; end
                   else if (t) begin
                       if (m_rem == 1) begin m_rem = 0; m_done = 1; m_st = 3; m_lock = 0; end
                       else if (m_rem > 0) m_rem--;
                   end
                2: if (ab) begin m_st = 0; m_rem = 0; end
                   else if (!cf) begin
                       if (irr) m_st = 1;
                       else begin m_st = 0; m_rem = 0; end
                   end
                default: if (ab) begin m_st = 0; m_rem = 0; end
                   else if (t) begin
                       m_lock++;
                       if (m_lock == LT) m_st = 0;
                   end
            endcase
        end
        m = m_rem / 6;
        e = {(m_st == 1) && m_mode, (m_st == 1) && !m_mode,
             4'(m / 10), 4'(m % 10), 4'(m_rem % 6), m_st != 0, m_done};
        sb_q.push_back(e);
    endtask

    // Drive one cycle, predict, then compare after the edge.
    task automatic step(input bit r, t, irr, md, cf, ab);
        logic [15:0] e;
        reset = r; tick = t; irrigation_on = irr;
        splinker_mode_on = md; conflicting_values = cf; abort = ab;
        model(r, t, irr, md, cf, ab);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 16'h0001, 16'h0000);
        end else begin
            e = sb_q.pop_front();
            chk("outs", dut_outs(), e);
        end
    endtask

    // Run n ticks, each followed by a non-tick cycle, holding irr/mode/conflict.
    task automatic ticks(input int n, input bit irr, input bit md);
        for (int i = 0; i < n; i++) begin
            step(0, 1, irr, md, 0, 0);
            if (i != n - 1) step(0, 0, irr, md, 0, 0);
        end
    endtask

    initial begin
        reset = 1; tick = 0; irrigation_on = 0; splinker_mode_on = 0;
        conflicting_values = 0; abort = 0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        chk("reset_outs", dut_outs(), 16'h0000);

        // sprinkler full run; tick on the load cycle is ignored
        step(0, 1, 1, 1, 0, 0);
        chk("spr_bomb", {15'd0, splinker_bomb}, 16'd1);
        chk("spr_preset", {4'd0, disp()}, 16'h0150);
        ticks(89, 1, 1);
        chk("spr_at_001", {4'd0, disp()}, 16'h0001);
        chk("spr_no_done_yet", {15'd0, done}, 16'd0);
        step(0, 1, 1, 1, 0, 0);
        chk("spr_done", {13'd0, done, splinker_bomb, busy}, 16'b101);
        step(0, 0, 1, 0, 0, 0);
        chk("done_one_cycle", {15'd0, done}, 16'd0);
        ticks(5, 1, 0);
        chk("lockout_busy", {15'd0, busy}, 16'd1);
        step(0, 0, 1, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        chk("lockout_end", {15'd0, busy}, 16'd0);

        // dripper with two-digit borrow; mode toggles ignored in RUN
        step(0, 0, 1, 0, 0, 0);
        chk("drp_preset", {4'd0, disp()}, 16'h0300);
        step(0, 1, 1, 1, 0, 0);
        chk("drp_295", {4'd0, disp()}, 16'h0295);
        ticks(5, 1, 1);
        chk("drp_290", {4'd0, disp()}, 16'h0290);
        ticks(6, 1, 0);
        chk("drp_280", {4'd0, disp()}, 16'h0280);
        chk("drp_valve_kept", {14'd0, splinker_bomb, dripper_valvule}, 16'b01);
        ticks(93, 1, 1);
        chk("drp_123", {4'd0, disp()}, 16'h0123);

        // hold: 20 cycles of fault with 3 ticks
        for (int i = 0; i < 20; i++) step(0, (i % 7) == 3, 1, 0, 1, 0);
        chk("hold_valve", {15'd0, dripper_valvule}, 16'd0);
        chk("hold_frozen", {4'd0, disp()}, 16'h0123);
        step(0, 0, 1, 0, 0, 0);
        chk("resume_valve", {15'd0, dripper_valvule}, 16'd1);
        step(0, 1, 1, 0, 0, 0);
        chk("resume_122", {4'd0, disp()}, 16'h0122);

        // drop request at 05:0
        ticks(44, 1, 0);
        chk("drp_050", {4'd0, disp()}, 16'h0050);
        step(0, 1, 0, 0, 0, 0);
        chk("drop_idle", dut_outs(), 16'h0000);

        // abort with tick at 00:1
        step(0, 0, 1, 1, 0, 0);
        ticks(89, 1, 1);
        chk("abort_pre", {4'd0, disp()}, 16'h0001);
        step(0, 1, 1, 1, 0, 1);
        chk("abort_idle", dut_outs(), 16'h0000);

        // reset mid-run
        step(0, 0, 1, 1, 0, 0);
        ticks(3, 1, 1);
        step(1, 1, 1, 1, 0, 0);
        chk("reset_midrun", dut_outs(), 16'h0000);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 39) != 0), $urandom_range(0, 1),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
